// File: rtl/photon_dbg_pkg.sv
// Shared types and defaults for the photon pipeline deadlock reporting slice.
package photon_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int DEF_N_MON  = 4;
  localparam int DEF_THRESH = 1024;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_TS_W   = 32;

  // A single monitor still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/photon_deadlock_reporter_if.sv
// Monitor-side inputs and status-side outputs of the deadlock reporter.
interface photon_deadlock_reporter_if
  import photon_dbg_pkg::*;
#(
  parameter int N_MON = DEF_N_MON,
  parameter int IDX_W = idx_width(N_MON),
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W
) ();

  logic             enable;
  logic [N_MON-1:0] block_vec;
  logic             report_ack;
  logic             deadlock;
  logic [IDX_W-1:0] deadlock_idx;
  logic [N_MON-1:0] deadlock_mask;
  logic [CNT_W-1:0] stall_count;
  logic [TS_W-1:0]  timestamp;
  logic             irq;

  modport master (
    output enable, block_vec, report_ack,
    input  deadlock, deadlock_idx, deadlock_mask, stall_count, timestamp, irq
  );

  modport slave (
    input  enable, block_vec, report_ack,
    output deadlock, deadlock_idx, deadlock_mask, stall_count, timestamp, irq
  );

endinterface

// File: rtl/photon_prio_enc.sv
// Combinational lowest-set-bit encoder with a valid flag.
module photon_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? W'(i) : idx_o;
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/photon_deadlock_reporter.sv
// Qualifies monitor block flags over THRESH consecutive cycles, then latches a
// sticky report (index, mask, timestamp) and pulses irq once per detection.
module photon_deadlock_reporter
  import photon_dbg_pkg::*;
#(
  parameter int N_MON  = DEF_N_MON,
  parameter int IDX_W  = idx_width(N_MON),
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH,
  parameter int TS_W   = DEF_TS_W
) (
  input logic                       clock,
  input logic                       reset,
  photon_deadlock_reporter_if.slave rpt
);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_QUAL   = 2'(ST_QUAL);
  localparam logic [1:0] S_REPORT = 2'(ST_REPORT);
  localparam logic [1:0] S_HOLD   = 2'(ST_HOLD);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             dl_q, dl_d;
  logic             irq_q, irq_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_MON-1:0] mask_q, mask_d;
  logic [TS_W-1:0]  tstamp_q, tstamp_d;
  logic [TS_W-1:0]  ts_q;

  logic [IDX_W-1:0] enc_idx_s;
  logic             blk_s;
  logic             detect_s;
  logic [CNT_W-1:0] stall_inc_s;
  logic [CNT_W-1:0] stall_sat_s;

  photon_prio_enc #(
    .N (N_MON),
    .W (IDX_W)
  ) u_enc (
    .vec_i   (rpt.block_vec),
    .idx_o   (enc_idx_s),
    .valid_o (blk_s)
  );

  assign stall_inc_s = stall_q + CNT_ONE;
  assign stall_sat_s = (stall_q == CNT_MAX) ? stall_q : stall_inc_s;

  // Next-state, stall counter and detection capture.
  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    dl_d     = dl_q;
    detect_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rpt.enable && blk_s) begin
          stall_d  = CNT_ONE;
          detect_s = (THRESH_C == CNT_ONE);
          state_d  = detect_s ? S_REPORT : S_QUAL;
        end else begin
          stall_d = '0;
        end
      end
      S_QUAL: begin
        if (!rpt.enable || !blk_s) begin
          state_d = S_IDLE;
          stall_d = '0;
        end else begin
          stall_d  = stall_inc_s;
          detect_s = (stall_inc_s == THRESH_C);
          state_d  = detect_s ? S_REPORT : S_QUAL;
        end
      end
      S_REPORT: begin
        stall_d = blk_s ? stall_sat_s : stall_q;
        if (rpt.report_ack) begin
          dl_d    = 1'b0;
          state_d = S_HOLD;
        end else begin
          dl_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!blk_s) begin
          state_d = S_IDLE;
          stall_d = '0;
        end else begin
          stall_d = stall_sat_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        stall_d = '0;
        dl_d    = 1'b0;
      end
    endcase
    dl_d     = dl_d | detect_s;
    irq_d    = detect_s;
    idx_d    = detect_s ? enc_idx_s     : idx_q;
    mask_d   = detect_s ? rpt.block_vec : mask_q;
    tstamp_d = detect_s ? ts_q          : tstamp_q;
  end

  // State, report registers and free-running cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stall_q  <= '0;
      dl_q     <= 1'b0;
      irq_q    <= 1'b0;
      idx_q    <= '0;
      mask_q   <= '0;
      tstamp_q <= '0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      dl_q     <= dl_d;
      irq_q    <= irq_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      tstamp_q <= tstamp_d;
      ts_q     <= ts_q + TS_W'(1);
    end
  end

  assign rpt.deadlock      = dl_q;
  assign rpt.irq           = irq_q;
  assign rpt.deadlock_idx  = idx_q;
  assign rpt.deadlock_mask = mask_q;
  assign rpt.stall_count   = stall_q;
  assign rpt.timestamp     = tstamp_q;

endmodule

// File: tb/tb_photon_deadlock_reporter.sv
// Bench for photon_deadlock_reporter: three builds (THRESH=8/CNT_W=16, THRESH=8/CNT_W=4,
// THRESH=1/CNT_W=16) share one stimulus stream and are checked against a cycle-level model.
module tb_photon_deadlock_reporter;
  import photon_dbg_pkg::*;

  localparam int NM  = 4;
  localparam int IW  = 2;
  localparam int TSW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  photon_deadlock_reporter_if #(.N_MON(NM), .IDX_W(IW), .CNT_W(16), .TS_W(TSW)) ifa ();
  photon_deadlock_reporter_if #(.N_MON(NM), .IDX_W(IW), .CNT_W(4),  .TS_W(TSW)) ifb ();
  photon_deadlock_reporter_if #(.N_MON(NM), .IDX_W(IW), .CNT_W(16), .TS_W(TSW)) ifc ();

  photon_deadlock_reporter #(.N_MON(NM), .IDX_W(IW), .CNT_W(16), .THRESH(8), .TS_W(TSW))
    dut_a (.clock(clock), .reset(reset), .rpt(ifa.slave));
  photon_deadlock_reporter #(.N_MON(NM), .IDX_W(IW), .CNT_W(4), .THRESH(8), .TS_W(TSW))
    dut_b (.clock(clock), .reset(reset), .rpt(ifb.slave));
  photon_deadlock_reporter #(.N_MON(NM), .IDX_W(IW), .CNT_W(16), .THRESH(1), .TS_W(TSW))
    dut_c (.clock(clock), .reset(reset), .rpt(ifc.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: per build, "reported" / "waiting for unblock" flags and a blocked-run count.
  int          m_th  [3] = '{8, 8, 1};
  int          m_max [3] = '{65535, 15, 65535};
  bit          m_dl  [3];
  bit          m_wait[3];
  bit          m_irq [3];
  int          m_stall[3];
  int          m_idx [3];
  logic [3:0]  m_mask[3];
  logic [31:0] m_tstamp[3];
  logic [31:0] m_ts;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input bit rst, input bit en, input logic [3:0] bv, input bit ack);
    bit blk;
    blk = (bv != 4'd0);
    for (int d = 0; d < 3; d++) begin
      m_irq[d] = 1'b0;
      if (rst) begin
        m_dl[d] = 0; m_wait[d] = 0; m_stall[d] = 0;
        m_idx[d] = 0; m_mask[d] = 4'd0; m_tstamp[d] = 32'd0;
      end else if (m_dl[d]) begin
        if (blk && m_stall[d] < m_max[d]) m_stall[d]++;
        if (ack) begin m_dl[d] = 0; m_wait[d] = 1; end
      end else if (m_wait[d]) begin
        if (!blk) begin m_wait[d] = 0; m_stall[d] = 0; end
        else if (m_stall[d] < m_max[d]) m_stall[d]++;
      end else if (en && blk) begin
        m_stall[d]++;
        if (m_stall[d] == m_th[d]) begin
          m_dl[d] = 1; m_irq[d] = 1; m_mask[d] = bv;
          m_idx[d] = lowest(bv); m_tstamp[d] = m_ts;
        end
      end else begin
        m_stall[d] = 0;
      end
    end
    m_ts = rst ? 32'd0 : m_ts + 32'd1;
  endtask

  task automatic cmp_dut(input int d, input string nm, input logic dl, input logic irq,
                         input logic [1:0] idx, input logic [3:0] mask,
                         input logic [15:0] stall, input logic [31:0] ts);
    check_eq({nm, ".deadlock"}, 64'(dl),    64'(m_dl[d]));
    check_eq({nm, ".irq"},      64'(irq),   64'(m_irq[d]));
    check_eq({nm, ".idx"},      64'(idx),   64'(m_idx[d]));
    check_eq({nm, ".mask"},     64'(mask),  64'(m_mask[d]));
    check_eq({nm, ".stall"},    64'(stall), 64'(m_stall[d]));
    check_eq({nm, ".tstamp"},   64'(ts),    64'(m_tstamp[d]));
  endtask

  // Applies one cycle of inputs; afterwards outputs of the following cycle are visible.
  task automatic step(input bit rst, input bit en, input logic [3:0] bv, input bit ack);
    reset = rst;
    ifa.enable = en; ifa.block_vec = bv; ifa.report_ack = ack;
    ifb.enable = en; ifb.block_vec = bv; ifb.report_ack = ack;
    ifc.enable = en; ifc.block_vec = bv; ifc.report_ack = ack;
    @(posedge clock);
    model_step(rst, en, bv, ack);
    @(negedge clock);
    cmp_dut(0, "a", ifa.deadlock, ifa.irq, ifa.deadlock_idx, ifa.deadlock_mask,
            ifa.stall_count, ifa.timestamp);
    cmp_dut(1, "b", ifb.deadlock, ifb.irq, ifb.deadlock_idx, ifb.deadlock_mask,
            16'(ifb.stall_count), ifb.timestamp);
    cmp_dut(2, "c", ifc.deadlock, ifc.irq, ifc.deadlock_idx, ifc.deadlock_mask,
            ifc.stall_count, ifc.timestamp);
    cyc = rst ? 0 : cyc + 1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] bv;
    bit en, ack, rst;
    int irqs;

    // Plan 1: block from cycle 10, detection visible in cycle 18, saturation at 40 cycles.
    do_reset();
    check_eq("rst.deadlock", 64'(ifa.deadlock), 64'd0);
    check_eq("rst.stall", 64'(ifa.stall_count), 64'd0);
    for (int c = 0; c < 50; c++) begin
      step(1'b0, 1'b1, (c >= 10) ? 4'b0100 : 4'b0000, 1'b0);
      if (c == 16) check_eq("p1.nodl17", 64'(ifa.deadlock), 64'd0);
      if (c == 17) begin
        check_eq("p1.dl", 64'(ifa.deadlock), 64'd1);
        check_eq("p1.irq", 64'(ifa.irq), 64'd1);
        check_eq("p1.idx", 64'(ifa.deadlock_idx), 64'd2);
        check_eq("p1.mask", 64'(ifa.deadlock_mask), 64'b0100);
        check_eq("p1.ts", 64'(ifa.timestamp), 64'd17);
        check_eq("p1.stall", 64'(ifa.stall_count), 64'd8);
      end
      if (c == 18) check_eq("p1.irq19", 64'(ifa.irq), 64'd0);
    end
    check_eq("p5.sat_b", 64'(ifb.stall_count), 64'd15);
    check_eq("p5.cnt_a", 64'(ifa.stall_count), 64'd40);

    // Plan 2: 7 blocked cycles fall short of the threshold.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, (c >= 10 && c <= 16) ? 4'b0001 : 4'b0000, 1'b0);
      if (c == 16) check_eq("p2.stall7", 64'(ifa.stall_count), 64'd7);
      if (c == 17) check_eq("p2.stall0", 64'(ifa.stall_count), 64'd0);
      if (c == 18) check_eq("p2.nodl", 64'(ifa.deadlock), 64'd0);
    end

    // Plan 3: ack, hold while still blocked, fresh detection after unblock.
    do_reset();
    irqs = 0;
    for (int c = 0; c < 72; c++) begin
      bv = (c < 5) ? 4'b0000 : (c <= 50) ? 4'b1010 : (c < 60) ? 4'b0000 : 4'b1000;
      step(1'b0, 1'b1, bv, c == 30);
      irqs += int'(ifa.irq);
      if (c == 12) begin
        check_eq("p3.idx", 64'(ifa.deadlock_idx), 64'd1);
        check_eq("p3.mask", 64'(ifa.deadlock_mask), 64'b1010);
      end
      if (c == 30) check_eq("p3.ackclr", 64'(ifa.deadlock), 64'd0);
      if (c == 67) check_eq("p3.reirq", 64'(ifa.irq), 64'd1);
    end
    check_eq("p3.irqcount", 64'(irqs), 64'd2);

    // Plan 4: enable drop restarts qualification; enable ignored once reported.
    do_reset();
    for (int c = 0; c < 35; c++) begin
      step(1'b0, !(c == 14 || c >= 25), (c >= 10) ? 4'b0110 : 4'b0000, 1'b0);
      if (c == 14) check_eq("p4.stall0", 64'(ifa.stall_count), 64'd0);
      if (c == 22) check_eq("p4.dl", 64'(ifa.deadlock), 64'd1);
      if (c == 33) check_eq("p4.sticky", 64'(ifa.deadlock), 64'd1);
    end

    // Plan 6: reset mid-qualification aborts; redetection needs 8 fresh cycles.
    do_reset();
    irqs = 0;
    for (int c = 0; c < 30; c++) begin
      step(c == 16, 1'b1, (c >= 10) ? 4'b0010 : 4'b0000, 1'b0);
      irqs += int'(ifa.irq);
      if (c == 16) check_eq("p6.stall0", 64'(ifa.stall_count), 64'd0);
      if (c == 23) check_eq("p6.nodl", 64'(ifa.deadlock), 64'd0);
      if (c == 24) check_eq("p6.redl", 64'(ifa.deadlock), 64'd1);
    end
    check_eq("p6.irqcount", 64'(irqs), 64'd1);

    // Randomized phase with run-length-biased blocking, sparse acks and resets.
    do_reset();
    bv = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0)
        bv = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
      en  = ($urandom_range(0, 19) != 0);
      ack = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, en, bv, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
